board_state: RTL and testbench

BOARD_STATE -- requirements
Module: board_state

---
 rtl/ttt_pkg.sv | 21 ++
 rtl/ttt_line_check.sv | 45 ++++
 rtl/board_state.sv | 104 ++++++++++
 tb/tb_board_state.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ttt_pkg.sv
// Shared encodings for the tic-tac-toe board: cell codes, player ids and FSM states.
package ttt_pkg;

  localparam logic [1:0] CELL_BLANK = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_EVAL = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  function automatic logic [1:0] player_code(input logic turn);
    return (turn == PLAYER_2) ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational win detector: scans every row, column and both diagonals of an
// N x N packed board and reports the first line filled with one player's code.
module ttt_line_check
  import ttt_pkg::*;
#(
  parameter int BOARD_DIM = 3
) (
  input  logic [2*BOARD_DIM*BOARD_DIM-1:0] board,
  output logic                             win,
  output logic [1:0]                       win_code
);

  localparam int N     = BOARD_DIM;
  localparam int LINES = 2 * N + 2;

  // Lines 0..N-1 are rows, N..2N-1 columns, then main and anti diagonal.
  function automatic int cell_of(input int line, input int pos);
    if (line < N)            return line * N + pos;
    else if (line < 2 * N)   return pos * N + (line - N);
    else if (line == 2 * N)  return pos * N + pos;
    else                     return pos * N + (N - 1 - pos);
  endfunction

  logic [1:0] first;
  logic       same;

  always_comb begin
    win      = 1'b0;
    win_code = CELL_BLANK;
    first    = CELL_BLANK;
    same     = 1'b0;
    for (int l = 0; l < LINES; l++) begin
      first = board[2*cell_of(l, 0) +: 2];
      same  = (first != CELL_BLANK);
      for (int p = 1; p < N; p++) begin
        if (board[2*cell_of(l, p) +: 2] != first) same = 1'b0;
      end
      if (same && !win) begin
        win      = 1'b1;
        win_code = first;
      end
    end
  end

endmodule

// File: rtl/board_state.sv
// Game board register and move FSM: validates placements on the rising edge of
// place, alternates players, then spends one cycle judging win/draw.
module board_state
  import ttt_pkg::*;
#(
  parameter int BOARD_DIM = 3,
  parameter int IDX_W     = 8
) (
  input  logic                                         clk,
  input  logic                                         clr,
  input  logic                                         place,
  input  logic [IDX_W-1:0]                             square_num,
  output logic [2*BOARD_DIM*BOARD_DIM-1:0]             board,
  output logic                                         player_turn,
  output logic                                         move_ok,
  output logic                                         move_err,
  output logic                                         game_over,
  output logic [1:0]                                   winner,
  output logic [$clog2(BOARD_DIM*BOARD_DIM+1)-1:0]     move_count
);

  localparam int                CELLS    = BOARD_DIM * BOARD_DIM;
  localparam int                CNT_W    = $clog2(CELLS + 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(CELLS);

  state_t     state;
  logic       place_q;
  logic       place_edge;
  logic       sq_free;
  logic       line_win;
  logic [1:0] line_code;

  assign place_edge = place & ~place_q;

  // Only an in-range square that is still blank can match here.
  always_comb begin
    sq_free = 1'b0;
    for (int k = 0; k < CELLS; k++) begin
      if (square_num == IDX_W'(k + 1)) sq_free = (board[2*k +: 2] == CELL_BLANK);
    end
  end

  ttt_line_check #(
    .BOARD_DIM (BOARD_DIM)
  ) u_line_check (
    .board    (board),
    .win      (line_win),
    .win_code (line_code)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= ST_PLAY;
      place_q     <= 1'b0;
      board       <= '0;
      player_turn <= PLAYER_1;
      move_count  <= '0;
      winner      <= CELL_BLANK;
      game_over   <= 1'b0;
      move_ok     <= 1'b0;
      move_err    <= 1'b0;
    end else begin
      place_q  <= place;
      move_ok  <= 1'b0;
      move_err <= 1'b0;
      case (state)
        ST_PLAY: begin
          if (place_edge) begin
            if (sq_free) begin
              for (int k = 0; k < CELLS; k++) begin
                if (square_num == IDX_W'(k + 1)) board[2*k +: 2] <= player_code(player_turn);
              end
              move_count  <= move_count + 1'b1;
              player_turn <= ~player_turn;
              move_ok     <= 1'b1;
              state       <= ST_EVAL;
            end else begin
              move_err <= 1'b1;
            end
          end
        end
        ST_EVAL: begin
          if (place_edge) move_err <= 1'b1;
          if (line_win) begin
            winner    <= line_code;
            game_over <= 1'b1;
            state     <= ST_OVER;
          end else if (move_count == FULL_CNT) begin
            winner    <= CELL_BLANK;
            game_over <= 1'b1;
            state     <= ST_OVER;
          end else begin
            state <= ST_PLAY;
          end
        end
        ST_OVER: begin
          if (place_edge) move_err <= 1'b1;
        end
        default: state <= ST_PLAY;
      endcase
    end
  end

endmodule

// File: tb/tb_board_state.sv
// Scoreboard bench for board_state: a 3x3 game model predicts each move response,
// a monitor checks it on every move pulse; a 4x4 instance covers the anti-diagonal.
module tb_board_state;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 3x3 instance
  logic        clr3 = 1'b0, place3 = 1'b0;
  logic [7:0]  sq3 = 8'd0;
  logic [17:0] board3;
  logic        turn3, ok3, err3, over3;
  logic [1:0]  win3;
  logic [3:0]  cnt3;

  board_state #(.BOARD_DIM(3), .IDX_W(8)) dut3 (
    .clk(clk), .clr(clr3), .place(place3), .square_num(sq3),
    .board(board3), .player_turn(turn3), .move_ok(ok3), .move_err(err3),
    .game_over(over3), .winner(win3), .move_count(cnt3)
  );

  // 4x4 instance
  logic        clr4 = 1'b0, place4 = 1'b0;
  logic [7:0]  sq4 = 8'd0;
  logic [31:0] board4;
  logic        turn4, ok4, err4, over4;
  logic [1:0]  win4;
  logic [4:0]  cnt4;

  board_state #(.BOARD_DIM(4), .IDX_W(8)) dut4 (
    .clk(clk), .clr(clr4), .place(place4), .square_num(sq4),
    .board(board4), .player_turn(turn4), .move_ok(ok4), .move_err(err4),
    .game_over(over4), .winner(win4), .move_count(cnt4)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          ok;
    logic [17:0] brd;
    logic        turn;
    int          cnt;
    logic        over;
    logic [1:0]  win;
    logic        post_over;
    logic [1:0]  post_win;
  } exp_t;

  exp_t exp_q[$];

  // Reference game model
  int         m_cell[1:9];
  logic       m_turn;
  int         m_cnt;
  logic       m_over;
  logic [1:0] m_win;
  int lines[8][3] = '{'{1,2,3}, '{4,5,6}, '{7,8,9}, '{1,4,7},
                      '{2,5,8}, '{3,6,9}, '{1,5,9}, '{3,5,7}};

  task automatic model_reset();
    for (int k = 1; k <= 9; k++) m_cell[k] = 0;
    m_turn = 1'b0; m_cnt = 0; m_over = 1'b0; m_win = 2'b00;
  endtask

  function automatic logic [17:0] m_board();
    logic [17:0] b;
    int v;
    b = '0;
    for (int k = 1; k <= 9; k++) begin
      v = m_cell[k];
      b[2*(k-1) +: 2] = v[1:0];
    end
    return b;
  endfunction

  function automatic logic [1:0] m_line_winner();
    int a;
    for (int i = 0; i < 8; i++) begin
      a = m_cell[lines[i][0]];
      if (a != 0 && m_cell[lines[i][1]] == a && m_cell[lines[i][2]] == a) return 2'(a);
    end
    return 2'b00;
  endfunction

  task automatic predict(input int sq);
    exp_t e;
    logic [1:0] w;
    if (!m_over && sq >= 1 && sq <= 9 && m_cell[sq] == 0) begin
      m_cell[sq] = m_turn ? 2 : 1;
      m_turn = ~m_turn;
      m_cnt++;
      e.ok = 1'b1; e.brd = m_board(); e.turn = m_turn; e.cnt = m_cnt;
      e.over = 1'b0; e.win = 2'b00;
      w = m_line_winner();
      if (w != 2'b00 || m_cnt == 9) begin
        m_over = 1'b1;
        m_win  = w;
      end
      e.post_over = m_over; e.post_win = m_win;
    end else begin
      e.ok = 1'b0; e.brd = m_board(); e.turn = m_turn; e.cnt = m_cnt;
      e.over = m_over; e.win = m_win;
      e.post_over = m_over; e.post_win = m_win;
    end
    exp_q.push_back(e);
  endtask

  // Monitor: compares on every move pulse, then checks game status one cycle later
  bit   pend = 1'b0;
  exp_t pend_e;

  always @(negedge clk) begin
    exp_t e;
    if (pend) begin
      chk("game_over_after_eval", 32'(over3), 32'(pend_e.post_over));
      chk("winner_after_eval", 32'(win3), 32'(pend_e.post_win));
      pend = 1'b0;
    end
    if (ok3 && err3) chk("ok_err_exclusive", 32'(1), 32'(0));
    if (ok3 || err3) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pulse", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("move_ok", 32'(ok3), 32'(e.ok));
        chk("move_err", 32'(err3), 32'(!e.ok));
        chk("board", 32'(board3), 32'(e.brd));
        chk("player_turn", 32'(turn3), 32'(e.turn));
        chk("move_count", 32'(cnt3), 32'(e.cnt));
        chk("game_over_at_pulse", 32'(over3), 32'(e.over));
        chk("winner_at_pulse", 32'(win3), 32'(e.win));
        if (e.ok) begin
          pend   = 1'b1;
          pend_e = e;
        end
      end
    end
  end

  task automatic check_reset3();
    chk("rst_board", 32'(board3), 32'(0));
    chk("rst_turn", 32'(turn3), 32'(0));
    chk("rst_count", 32'(cnt3), 32'(0));
    chk("rst_winner", 32'(win3), 32'(0));
    chk("rst_game_over", 32'(over3), 32'(0));
    chk("rst_move_ok", 32'(ok3), 32'(0));
    chk("rst_move_err", 32'(err3), 32'(0));
  endtask

  task automatic clear3();
    @(posedge clk); #1;
    clr3 = 1'b1;
    @(posedge clk); #1;
    clr3 = 1'b0;
    model_reset();
    check_reset3();
  endtask

  task automatic move3(input int sq, input int hold = 1);
    @(posedge clk); #1;
    sq3 = 8'(sq);
    place3 = 1'b1;
    predict(sq);
    repeat (hold) @(posedge clk);
    #1;
    place3 = 1'b0;
    sq3 = 8'($urandom_range(0, 255));
    repeat (3) @(posedge clk);
  endtask

  task automatic move4(input int sq);
    @(posedge clk); #1;
    sq4 = 8'(sq);
    place4 = 1'b1;
    @(posedge clk); #1;
    place4 = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int seq_win[5]  = '{1, 4, 2, 5, 3};
    int seq_draw[9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};
    int seq_4[8]    = '{1, 4, 2, 7, 3, 10, 5, 13};
    int sq;

    model_reset();
    clear3();

    // First move and occupied-cell rejection
    move3(5);
    move3(5);

    // Row win for player 1, then a late move is refused
    clear3();
    foreach (seq_win[i]) move3(seq_win[i]);
    move3(9);

    // Full board with no line
    clear3();
    foreach (seq_draw[i]) move3(seq_draw[i]);
    chk("draw_count", 32'(cnt3), 32'(9));

    // Out-of-range squares and a long-held press
    clear3();
    move3(0);
    move3(10);
    move3(7, 20);

    // clr in the same cycle as a press edge wins
    @(posedge clk); #1;
    sq3 = 8'd3; place3 = 1'b1; clr3 = 1'b1;
    @(posedge clk); #1;
    place3 = 1'b0; clr3 = 1'b0;
    model_reset();
    check_reset3();
    repeat (3) @(posedge clk);
    #1;
    check_reset3();

    // Random games
    for (int g = 0; g < 8; g++) begin
      clear3();
      for (int m = 0; m < 14; m++) begin
        sq = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 12) : $urandom_range(1, 9);
        move3(sq);
        if (m_over && $urandom_range(0, 1) == 0) break;
      end
      move3($urandom_range(1, 9));
    end

    // 4x4 anti-diagonal win for player 2
    @(posedge clk); #1; clr4 = 1'b1;
    @(posedge clk); #1; clr4 = 1'b0;
    chk("n4_rst_board", board4, 32'(0));
    for (int i = 0; i < 7; i++) move4(seq_4[i]);
    chk("n4_not_over_yet", 32'(over4), 32'(0));
    move4(seq_4[7]);
    chk("n4_winner", 32'(win4), 32'(2'b10));
    chk("n4_game_over", 32'(over4), 32'(1));
    chk("n4_count", 32'(cnt4), 32'(8));
    chk("n4_cell13", 32'(board4[25:24]), 32'(2'b10));

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
